nanorv32_periph_bridge: RTL and testbench

//  Data-side address decoder and APB-style peripheral bridge between the nanorv32 data interface and
//  the TCM arbitrer. TCM-region accesses pass straight through to the arbitrer data port; peripheral-

---
 rtl/nanorv32_periph_bridge_pkg.sv | 22 ++
 rtl/nanorv32_periph_bridge_addr_decode.sv | 25 ++
 rtl/nanorv32_periph_bridge.sv | 179 +++++++++++++++++
 tb/tb_nanorv32_periph_bridge.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nanorv32_periph_bridge_pkg.sv
// nanorv32_periph_bridge_pkg: shared constants, FSM state encoding and the
// peripheral-window decode helper used by the data-side bridge.
package nanorv32_periph_bridge_pkg;

  // Peripheral bridge transfer phases
  typedef enum logic [1:0] {
    PB_IDLE   = 2'd0,
    PB_SETUP  = 2'd1,
    PB_ACCESS = 2'd2
  } pb_state_e;

  localparam logic [31:0] PB_DEFAULT_PERIPH_BASE = 32'h0001_0000;
  localparam logic [31:0] PB_DEFAULT_PERIPH_MASK = 32'hFFFF_0000;

  // True when the address falls inside the peripheral window
  function automatic logic pb_addr_hit(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] mask);
    return ((addr & mask) == base);
  endfunction

endpackage

// File: rtl/nanorv32_periph_bridge_addr_decode.sv
// nanorv32_addr_decode: combinational peripheral-window decode and TCM request
// gating. TCM requests are only forwarded while the bridge FSM is idle.
module nanorv32_addr_decode
  import nanorv32_periph_bridge_pkg::*;
#(
  parameter logic [31:0] PERIPH_BASE = PB_DEFAULT_PERIPH_BASE,
  parameter logic [31:0] PERIPH_MASK = PB_DEFAULT_PERIPH_MASK
) (
  input  logic [31:0] i_addr,
  input  logic        i_req,
  input  logic        i_idle,
  output logic        o_hit,
  output logic        o_tcm_req
);

  logic w_hit;

  // Decode the window and gate the TCM-path request
  always_comb begin
    w_hit     = pb_addr_hit(i_addr, PERIPH_BASE, PERIPH_MASK);
    o_hit     = w_hit;
    o_tcm_req = i_req & ~w_hit & i_idle;
  end

endmodule

// File: rtl/nanorv32_periph_bridge.sv
// nanorv32_periph_bridge: data-side address decoder and APB-style peripheral
// bridge. TCM-window accesses pass straight to the arbitrer; peripheral-window
// accesses run a SETUP/ACCESS transfer with wait states.
// Optional feature macro: NANORV32_PERIPH_TIMEOUT_EN (ACCESS wait timeout).
module nanorv32_periph_bridge
  import nanorv32_periph_bridge_pkg::*;
#(
  parameter logic [31:0] PERIPH_BASE = PB_DEFAULT_PERIPH_BASE,
  parameter logic [31:0] PERIPH_MASK = PB_DEFAULT_PERIPH_MASK,
  parameter int          PADDR_W     = 12
`ifdef NANORV32_PERIPH_TIMEOUT_EN
  ,
  parameter int          TIMEOUT     = 255
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        cpu_dataif_addr,
  input  logic [31:0]        cpu_dataif_wdata,
  input  logic [3:0]         cpu_dataif_bytesel,
  input  logic               cpu_dataif_req,
  output logic [31:0]        dataif_cpu_rdata,
  output logic               dataif_cpu_early_ready,
  output logic               dataif_cpu_ready_r,
  output logic [31:0]        brg_dataif_addr,
  output logic [31:0]        brg_dataif_wdata,
  output logic [3:0]         brg_dataif_bytesel,
  output logic               brg_dataif_req,
  input  logic [31:0]        arb_dataif_rdata,
  input  logic               arb_dataif_early_ready,
  input  logic               arb_dataif_ready_r,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [PADDR_W-1:0] paddr,
  output logic [31:0]        pwdata,
  output logic [3:0]         pstrb,
  input  logic [31:0]        prdata,
  input  logic               pready,
  input  logic               pslverr,
  output logic               periph_err
);

  pb_state_e          r_state;
  logic               r_psel;
  logic               r_penable;
  logic               r_pwrite;
  logic [PADDR_W-1:0] r_paddr;
  logic [31:0]        r_pwdata;
  logic [3:0]         r_pstrb;
  logic [31:0]        r_rdata;
  logic               r_ready;
  logic               r_err;
  logic               r_sel_periph;

  logic               w_hit;
  logic               w_idle;
  logic               w_timeout;
  logic               w_done;
  logic               w_fail;
  logic               w_sel_periph;

  assign w_idle = (r_state == PB_IDLE);

  nanorv32_addr_decode #(
    .PERIPH_BASE (PERIPH_BASE),
    .PERIPH_MASK (PERIPH_MASK)
  ) u_decode (
    .i_addr    (cpu_dataif_addr),
    .i_req     (cpu_dataif_req),
    .i_idle    (w_idle),
    .o_hit     (w_hit),
    .o_tcm_req (brg_dataif_req)
  );

  assign brg_dataif_addr    = cpu_dataif_addr;
  assign brg_dataif_wdata   = cpu_dataif_wdata;
  assign brg_dataif_bytesel = cpu_dataif_bytesel;

`ifdef NANORV32_PERIPH_TIMEOUT_EN
  // The cycle on which the counter already holds TIMEOUT-1 is the final allowed wait
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] r_wait_cnt;

  assign w_timeout = (r_state == PB_ACCESS) & ~pready & (r_wait_cnt == TO_LAST);

  // Count ACCESS wait cycles; cleared when a transfer is accepted into SETUP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
    end else if (w_idle && cpu_dataif_req && w_hit) begin
      r_wait_cnt <= 8'd0;
    end else if ((r_state == PB_ACCESS) && !pready && !w_timeout) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Completion and error qualifiers of the ACCESS phase
  always_comb begin
    w_done = (r_state == PB_ACCESS) & (pready | w_timeout);
    w_fail = (r_state == PB_ACCESS) & ((pready & pslverr) | w_timeout);
  end

  // Bridge FSM with registered peripheral bus signals and CPU completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= PB_IDLE;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= 32'h0;
      r_pstrb      <= 4'h0;
      r_rdata      <= 32'h0;
      r_ready      <= 1'b0;
      r_err        <= 1'b0;
      r_sel_periph <= 1'b0;
    end else begin
      r_ready <= 1'b0;
      // A TCM completion returns the read mux to the arbitrer path
      if (arb_dataif_ready_r) begin
        r_sel_periph <= 1'b0;
      end
      case (r_state)
        PB_IDLE: begin
          if (cpu_dataif_req && w_hit) begin
            r_paddr  <= cpu_dataif_addr[PADDR_W-1:0];
            r_pwdata <= cpu_dataif_wdata;
            r_pstrb  <= cpu_dataif_bytesel;
            r_pwrite <= |cpu_dataif_bytesel;
            r_psel   <= 1'b1;
            r_state  <= PB_SETUP;
          end
        end
        PB_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= PB_ACCESS;
        end
        PB_ACCESS: begin
          if (w_done) begin
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_ready      <= 1'b1;
            r_sel_periph <= 1'b1;
            r_rdata      <= (r_pwrite || w_fail) ? 32'h0 : prdata;
            r_state      <= PB_IDLE;
            if (w_fail) begin
              r_err <= 1'b1;
            end
          end
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= PB_IDLE;
        end
      endcase
    end
  end

  // Arbitrer data wins on the cycle its ready_r arrives, before the flag clears
  assign w_sel_periph = r_sel_periph & ~arb_dataif_ready_r;

  assign dataif_cpu_rdata       = w_sel_periph ? r_rdata : arb_dataif_rdata;
  assign dataif_cpu_early_ready = arb_dataif_early_ready | w_done;
  assign dataif_cpu_ready_r     = arb_dataif_ready_r | r_ready;

  assign psel       = r_psel;
  assign penable    = r_penable;
  assign pwrite     = r_pwrite;
  assign paddr      = r_paddr;
  assign pwdata     = r_pwdata;
  assign pstrb      = r_pstrb;
  assign periph_err = r_err;

endmodule

// File: tb/tb_nanorv32_periph_bridge.sv
// tb_nanorv32_periph_bridge: self-checking bench for the data-side bridge.
// Expected behaviour comes from a transaction-level model: each peripheral
// transfer completes (early_ready) 2+waits cycles after its request and shows
// ready_r/rdata one cycle later; periph_err is the OR of all failed transfers.
module tb_nanorv32_periph_bridge;

  logic        clk;
  logic        rst_n;
  logic [31:0] cpu_dataif_addr;
  logic [31:0] cpu_dataif_wdata;
  logic [3:0]  cpu_dataif_bytesel;
  logic        cpu_dataif_req;
  logic [31:0] dataif_cpu_rdata;
  logic        dataif_cpu_early_ready;
  logic        dataif_cpu_ready_r;
  logic [31:0] brg_dataif_addr;
  logic [31:0] brg_dataif_wdata;
  logic [3:0]  brg_dataif_bytesel;
  logic        brg_dataif_req;
  logic [31:0] arb_dataif_rdata;
  logic        arb_dataif_early_ready;
  logic        arb_dataif_ready_r;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic        periph_err;

  int          n_checks;
  int          n_fail;
  bit          pending;
  logic [31:0] pend_rdata;
  bit          err_model;

  nanorv32_periph_bridge dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .cpu_dataif_addr        (cpu_dataif_addr),
    .cpu_dataif_wdata       (cpu_dataif_wdata),
    .cpu_dataif_bytesel     (cpu_dataif_bytesel),
    .cpu_dataif_req         (cpu_dataif_req),
    .dataif_cpu_rdata       (dataif_cpu_rdata),
    .dataif_cpu_early_ready (dataif_cpu_early_ready),
    .dataif_cpu_ready_r     (dataif_cpu_ready_r),
    .brg_dataif_addr        (brg_dataif_addr),
    .brg_dataif_wdata       (brg_dataif_wdata),
    .brg_dataif_bytesel     (brg_dataif_bytesel),
    .brg_dataif_req         (brg_dataif_req),
    .arb_dataif_rdata       (arb_dataif_rdata),
    .arb_dataif_early_ready (arb_dataif_early_ready),
    .arb_dataif_ready_r     (arb_dataif_ready_r),
    .psel                   (psel),
    .penable                (penable),
    .pwrite                 (pwrite),
    .paddr                  (paddr),
    .pwdata                 (pwdata),
    .pstrb                  (pstrb),
    .prdata                 (prdata),
    .pready                 (pready),
    .pslverr                (pslverr),
    .periph_err             (periph_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rand_tcm_addr();
    logic [31:0] a;
    a = $urandom;
    if ((a & 32'hFFFF_0000) == 32'h0001_0000) a = a ^ 32'h0010_0000;
    return a;
  endfunction

  task automatic drive_quiet();
    cpu_dataif_req         = 1'b0;
    cpu_dataif_addr        = 32'h0;
    cpu_dataif_wdata       = 32'h0;
    cpu_dataif_bytesel     = 4'h0;
    arb_dataif_rdata       = 32'h0;
    arb_dataif_early_ready = 1'b0;
    arb_dataif_ready_r     = 1'b0;
    prdata                 = 32'h0;
    pready                 = 1'b0;
    pslverr                = 1'b0;
  endtask

  task automatic test_reset();
    drive_quiet();
    rst_n = 1'b0;
    arb_dataif_rdata = 32'h5A5A_1234;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({psel, penable, pwrite, periph_err, dataif_cpu_ready_r, dataif_cpu_early_ready} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b want 000000",
               {psel, penable, pwrite, periph_err, dataif_cpu_ready_r, dataif_cpu_early_ready});
    end
    n_checks++;
    if ({paddr, pwdata, pstrb} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_bus: got %h want 0", {paddr, pwdata, pstrb});
    end
    n_checks++;
    if (dataif_cpu_rdata !== 32'h5A5A_1234) begin
      n_fail++;
      $display("FAIL reset_rdata_mux: got %h want 5a5a1234", dataif_cpu_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    arb_dataif_rdata = 32'h0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({psel, penable, dataif_cpu_ready_r, periph_err} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_release: got %b want 0000",
               {psel, penable, dataif_cpu_ready_r, periph_err});
    end
    pending   = 1'b0;
    err_model = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    drive_quiet();
    #1;
    n_checks++;
    if ({psel, penable, dataif_cpu_ready_r, brg_dataif_req} !== {2'b00, pending, 1'b0}) begin
      n_fail++;
      $display("FAIL idle_ctl: got %b want %b",
               {psel, penable, dataif_cpu_ready_r, brg_dataif_req}, {2'b00, pending, 1'b0});
    end
    if (pending) begin
      n_checks++;
      if (dataif_cpu_rdata !== pend_rdata) begin
        n_fail++;
        $display("FAIL idle_rdata: got %h want %h", dataif_cpu_rdata, pend_rdata);
      end
    end
    n_checks++;
    if (periph_err !== err_model) begin
      n_fail++;
      $display("FAIL idle_err: got %b want %b", periph_err, err_model);
    end
    pending = 1'b0;
  endtask

  // Peripheral transfer: request in cycle 0, SETUP in 1, ACCESS from 2, done at 2+waits
  task automatic run_periph(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] bsel, input int waits,
                            input bit slverr, input logic [31:0] rd_val);
    int          last;
    logic        exp_wr;
    logic [31:0] exp_rdata;
    last      = 2 + waits;
    exp_wr    = |bsel;
    exp_rdata = (exp_wr || slverr) ? 32'h0 : rd_val;
    for (int c = 0; c <= last; c++) begin
      @(negedge clk);
      cpu_dataif_req         = 1'b1;
      arb_dataif_rdata       = 32'h0;
      arb_dataif_early_ready = 1'b0;
      arb_dataif_ready_r     = 1'b0;
      if (c == 0) begin
        cpu_dataif_addr    = addr;
        cpu_dataif_wdata   = wdata;
        cpu_dataif_bytesel = bsel;
      end else begin
        cpu_dataif_addr    = $urandom;
        cpu_dataif_wdata   = $urandom;
        cpu_dataif_bytesel = 4'($urandom);
      end
      pready  = (c == last);
      pslverr = (c == last) ? slverr : 1'($urandom);
      prdata  = (c == last) ? rd_val : $urandom;
      #1;
      if (c == 0) begin
        n_checks++;
        if ({psel, penable, dataif_cpu_ready_r, dataif_cpu_early_ready, brg_dataif_req} !==
            {2'b00, pending, 2'b00}) begin
          n_fail++;
          $display("FAIL periph_req_ctl: got %b want %b",
                   {psel, penable, dataif_cpu_ready_r, dataif_cpu_early_ready, brg_dataif_req},
                   {2'b00, pending, 2'b00});
        end
        if (pending) begin
          n_checks++;
          if (dataif_cpu_rdata !== pend_rdata) begin
            n_fail++;
            $display("FAIL periph_prev_rdata: got %h want %h", dataif_cpu_rdata, pend_rdata);
          end
        end
        n_checks++;
        if (periph_err !== err_model) begin
          n_fail++;
          $display("FAIL periph_err: got %b want %b", periph_err, err_model);
        end
        pending = 1'b0;
      end else begin
        n_checks++;
        if ({psel, penable, dataif_cpu_ready_r, dataif_cpu_early_ready, brg_dataif_req} !==
            {1'b1, (c >= 2), 1'b0, (c == last), 1'b0}) begin
          n_fail++;
          $display("FAIL periph_phase c=%0d: got %b want %b", c,
                   {psel, penable, dataif_cpu_ready_r, dataif_cpu_early_ready, brg_dataif_req},
                   {1'b1, (c >= 2), 1'b0, (c == last), 1'b0});
        end
        n_checks++;
        if ({pwrite, paddr, pwdata, pstrb} !== {exp_wr, addr[11:0], wdata, bsel}) begin
          n_fail++;
          $display("FAIL periph_bus c=%0d: got %h want %h", c,
                   {pwrite, paddr, pwdata, pstrb}, {exp_wr, addr[11:0], wdata, bsel});
        end
      end
    end
    pending    = 1'b1;
    pend_rdata = exp_rdata;
    err_model  = err_model | slverr;
  endtask

  // TCM transfer: pass-through request, arbitrer answers early then ready_r
  task automatic run_tcm(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] bsel, input logic [31:0] rd_val);
    @(negedge clk);
    drive_quiet();
    cpu_dataif_req     = 1'b1;
    cpu_dataif_addr    = addr;
    cpu_dataif_wdata   = wdata;
    cpu_dataif_bytesel = bsel;
    #1;
    n_checks++;
    if ({brg_dataif_req, psel, dataif_cpu_ready_r} !== {2'b10, pending}) begin
      n_fail++;
      $display("FAIL tcm_req_ctl: got %b want %b",
               {brg_dataif_req, psel, dataif_cpu_ready_r}, {2'b10, pending});
    end
    n_checks++;
    if ({brg_dataif_addr, brg_dataif_wdata, brg_dataif_bytesel} !== {addr, wdata, bsel}) begin
      n_fail++;
      $display("FAIL tcm_passthru: got %h want %h",
               {brg_dataif_addr, brg_dataif_wdata, brg_dataif_bytesel}, {addr, wdata, bsel});
    end
    if (pending) begin
      n_checks++;
      if (dataif_cpu_rdata !== pend_rdata) begin
        n_fail++;
        $display("FAIL tcm_prev_rdata: got %h want %h", dataif_cpu_rdata, pend_rdata);
      end
    end
    pending = 1'b0;
    @(negedge clk);
    arb_dataif_early_ready = 1'b1;
    #1;
    n_checks++;
    if ({dataif_cpu_early_ready, dataif_cpu_ready_r, brg_dataif_req} !== 3'b101) begin
      n_fail++;
      $display("FAIL tcm_early: got %b want 101",
               {dataif_cpu_early_ready, dataif_cpu_ready_r, brg_dataif_req});
    end
    @(negedge clk);
    cpu_dataif_req         = 1'b0;
    arb_dataif_early_ready = 1'b0;
    arb_dataif_ready_r     = 1'b1;
    arb_dataif_rdata       = rd_val;
    #1;
    n_checks++;
    if ({dataif_cpu_ready_r, dataif_cpu_rdata} !== {1'b1, rd_val}) begin
      n_fail++;
      $display("FAIL tcm_ready_rdata: got %b/%h want 1/%h",
               dataif_cpu_ready_r, dataif_cpu_rdata, rd_val);
    end
  endtask

  task automatic test_tcm_read();
    run_tcm(32'h0000_0100, 32'h0, 4'h0, 32'hDEAD_0100);
    for (int i = 0; i < 4; i++) run_tcm(rand_tcm_addr(), $urandom, 4'($urandom), $urandom);
    idle_cycle();
  endtask

  task automatic test_periph_read();
    run_periph(32'h0001_0004, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_F00D);
    idle_cycle();
  endtask

  task automatic test_periph_write();
    run_periph(32'h0001_0008, 32'h1234_5678, 4'b0011, 3, 1'b0, 32'hFFFF_FFFF);
    idle_cycle();
  endtask

  task automatic test_slverr();
    run_periph(32'h0001_00C0, 32'h0, 4'h0, 1, 1'b1, 32'h1111_2222);
    idle_cycle();
    run_periph(32'h0001_00C4, 32'h0, 4'h0, 0, 1'b0, 32'h3333_4444);
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    run_periph(32'h0001_0020, 32'h0, 4'h0, 0, 1'b0, 32'hA5A5_0001);
    run_periph(32'h0001_0024, 32'hBEEF_0002, 4'b1111, 2, 1'b0, 32'h0);
    run_periph(32'h0001_0028, 32'h0, 4'h0, 40, 1'b0, 32'h0BAD_CAFE);
    run_tcm(32'h0000_0200, 32'h0, 4'h0, 32'h7777_0200);
    idle_cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        run_tcm(rand_tcm_addr(), $urandom, 4'($urandom), $urandom);
      end else begin
        run_periph({16'h0001, 16'($urandom)}, $urandom,
                   ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                   $urandom_range(0, 4), ($urandom_range(0, 3) == 0), $urandom);
      end
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_quiet();
      cpu_dataif_req  = 1'b1;
      cpu_dataif_addr = 32'h0001_0040;
    end
    #1;
    n_checks++;
    if ({psel, penable} !== 2'b11) begin
      n_fail++;
      $display("FAIL rstmid_access: got %b want 11", {psel, penable});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({psel, penable, dataif_cpu_ready_r, periph_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rstmid_abort: got %b want 0000",
               {psel, penable, dataif_cpu_ready_r, periph_err});
    end
    @(negedge clk);
    drive_quiet();
    rst_n     = 1'b1;
    pending   = 1'b0;
    err_model = 1'b0;
    idle_cycle();
  endtask

`ifdef NANORV32_PERIPH_TIMEOUT_EN
  task automatic test_timeout();
    int done_c;
    done_c = -1;
    @(negedge clk);
    drive_quiet();
    cpu_dataif_req  = 1'b1;
    cpu_dataif_addr = 32'h0001_0080;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      cpu_dataif_req = 1'b0;
      #1;
      if (dataif_cpu_early_ready === 1'b1) begin
        done_c = c;
        break;
      end
    end
    n_checks++;
    if (done_c != 256) begin
      n_fail++;
      $display("FAIL timeout_cycle: got %0d want 256", done_c);
    end
    pending    = 1'b1;
    pend_rdata = 32'h0;
    err_model  = 1'b1;
    idle_cycle();
  endtask
`endif

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    pending    = 1'b0;
    pend_rdata = 32'h0;
    err_model  = 1'b0;
    rst_n      = 1'b0;
    drive_quiet();
    test_reset();
    test_tcm_read();
    test_periph_read();
    test_periph_write();
    test_slverr();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef NANORV32_PERIPH_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
